pixel_stream_buf: RTL and testbench

Parametrised single-frame pixel buffer with a write port and a raster-order streaming read engine. The host writes pixels at random addresses. A `start` pulse then streams the whole frame out over a valid/ready interface, tagged with start-of-frame, end-of-line and end-of-frame flags. It sits between the image source and the histogram datapath and replaces the fixed, address-driven input RAM with a back-pressurable stream source.

---
 rtl/pixel_stream_buf.sv | 149 ++++++++++++++
 tb/tb_pixel_stream_buf.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_buf.sv
// Single-frame pixel buffer with a random-access write port and a raster-order
// valid/ready readout engine.
module pixel_stream_buf #(
    parameter int unsigned W               = 2,
    parameter int unsigned H               = 5,
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned TOTAL_PIXEL     = W * H,
    parameter int unsigned TOTAL_PIXEL_BIT = (TOTAL_PIXEL > 1) ? $clog2(TOTAL_PIXEL) : 1,
    parameter              INIT_FILE       = "pixel_in.hex"
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [TOTAL_PIXEL_BIT-1:0] wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       start,
    output logic                       busy,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_W-1:0]          m_data,
    output logic                       m_sof,
    output logic                       m_eol,
    output logic                       m_eof,
    output logic                       frame_done
);

    localparam int unsigned XW = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned EW = DATA_W + 3;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [TOTAL_PIXEL_BIT-1:0] PTR_LAST = TOTAL_PIXEL_BIT'(TOTAL_PIXEL - 1);
    localparam logic [XW-1:0]              X_LAST   = XW'(W - 1);

    logic [DATA_W-1:0]          mem [TOTAL_PIXEL];
    logic [1:0]                 state;
    logic [1:0]                 state_nxt;
    logic [TOTAL_PIXEL_BIT-1:0] rd_ptr;
    logic [XW-1:0]              x_cnt;
    logic                       issue_done;
    logic [1:0]                 occ;
    logic [EW-1:0]              skid;
    logic                       issue_c;
    logic                       pop_c;
    logic                       start_ok_c;
    logic [EW-1:0]              rd_entry_c;

    // Frame storage; no reset so contents survive rst_n, read-first on collision.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < TOTAL_PIXEL)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign start_ok_c = (state == S_IDLE) && start;
    assign issue_c    = (state == S_STREAM) && !issue_done && (occ < 2'd2);
    assign pop_c      = m_valid && m_ready;
    assign rd_entry_c = {mem[rd_ptr], rd_ptr == '0, x_cnt == X_LAST, rd_ptr == PTR_LAST};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start)          state_nxt = S_STREAM;
            S_STREAM: if (pop_c && m_eof) state_nxt = S_DONE;
            S_DONE:                       state_nxt = S_IDLE;
            default:                      state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            busy       <= (state_nxt != S_IDLE);
            frame_done <= (state_nxt == S_DONE);
        end
    end

    // Read pointer saturates at the last pixel; issue_done blocks further reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            x_cnt      <= '0;
            issue_done <= 1'b1;
        end else if (start_ok_c) begin
            rd_ptr     <= '0;
            x_cnt      <= '0;
            issue_done <= 1'b0;
        end else if (issue_c) begin
            if (rd_ptr == PTR_LAST) begin
                issue_done <= 1'b1;
            end else begin
                rd_ptr <= rd_ptr + TOTAL_PIXEL_BIT'(1);
            end
            x_cnt <= (x_cnt == X_LAST) ? '0 : x_cnt + XW'(1);
        end
    end

    // Two-entry skid: head drives the stream outputs, skid holds the second entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ     <= 2'd0;
            skid    <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
            m_eof   <= 1'b0;
        end else begin
            case ({issue_c, pop_c})
                2'b10: begin
                    if (occ == 2'd0) begin
                        {m_data, m_sof, m_eol, m_eof} <= rd_entry_c;
                    end else begin
                        skid <= rd_entry_c;
                    end
                    occ     <= occ + 2'd1;
                    m_valid <= 1'b1;
                end
                2'b01: begin
                    {m_data, m_sof, m_eol, m_eof} <= skid;
                    occ     <= occ - 2'd1;
                    m_valid <= (occ == 2'd2);
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        {m_data, m_sof, m_eol, m_eof} <= rd_entry_c;
                    end else begin
                        {m_data, m_sof, m_eol, m_eof} <= skid;
                        skid <= rd_entry_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_stream_buf.sv
// Directed self-checking bench for pixel_stream_buf (W=2, H=5, default build).
module tb_pixel_stream_buf;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       busy;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_sof;
    logic       m_eol;
    logic       m_eof;
    logic       frame_done;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] exp_mem [10];

    pixel_stream_buf dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .busy       (busy),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_sof      (m_sof),
        .m_eol      (m_eol),
        .m_eof      (m_eof),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame: start in the current cycle, then follow the stream until busy falls.
    task automatic run_frame(input bit bp, input bit inject);
        int cyc;
        int got;
        int dones;
        int fall_cyc;
        bit stalled;
        logic [7:0] held;
        start = 1'b1;
        m_ready = 1'b1;
        step();
        start = 1'b0;
        chk("busy_c1", busy, 1);
        chk("valid_c1", m_valid, 0);
        cyc = 2;
        got = 0;
        dones = 0;
        fall_cyc = -1;
        stalled = 1'b0;
        held = '0;
        step();
        while (cyc < 80 && fall_cyc < 0) begin
            m_ready = bp ? ((cyc % 3) == 2) : 1'b1;
            wr_en   = inject && (cyc == 2);
            wr_addr = 4'd9;
            wr_data = 8'h5A;
            start   = inject && (cyc == 3);
            if (stalled) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, held);
            end
            if (m_valid && m_ready) begin
                if (got < 10) begin
                    chk("pix_data", m_data, exp_mem[got]);
                    chk("pix_sof", m_sof, got == 0);
                    chk("pix_eol", m_eol, (got % 2) == 1);
                    chk("pix_eof", m_eof, got == 9);
                    if (!bp && got == 0) chk("first_cyc", cyc, 2);
                end else begin
                    chk("extra_pixel", got, 9);
                end
                got++;
            end
            stalled = m_valid && !m_ready;
            held = m_data;
            if (frame_done) begin
                dones++;
                if (!bp) chk("done_cyc", cyc, 12);
            end
            if (dones > 0 && !busy) fall_cyc = cyc;
            step();
            cyc++;
        end
        wr_en = 1'b0;
        start = 1'b0;
        chk("pix_count", got, 10);
        chk("done_count", dones, 1);
        if (!bp) chk("busy_fall_cyc", fall_cyc, 13);
        else     chk("busy_fell", fall_cyc >= 0, 1);
        chk("done_low_idle", frame_done, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_flags", {m_sof, m_eol, m_eof}, 0);
        chk("rst_done", frame_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Load F0..F9, then an out-of-range write that must be dropped.
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1;
            wr_addr = 4'(i);
            wr_data = 8'(8'hF0 + i);
            exp_mem[i] = 8'(8'hF0 + i);
            step();
        end
        wr_addr = 4'd10;
        wr_data = 8'h33;
        step();
        wr_en = 1'b0;
        step();
        chk("idle_busy", busy, 0);

        run_frame(1'b0, 1'b0);
        run_frame(1'b1, 1'b0);

        // Reset after pixel 3 is accepted.
        start = 1'b1;
        m_ready = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("pre_rst_data", m_data, 8'hF4);
        chk("pre_rst_valid", m_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_data", m_data, 0);
        chk("mid_rst_flags", {m_sof, m_eol, m_eof}, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_no_done", frame_done, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_done", frame_done, 0);
        run_frame(1'b0, 1'b0);

        // Write to pixel 9 during readout and a redundant start while busy.
        exp_mem[9] = 8'h5A;
        run_frame(1'b0, 1'b1);
        run_frame(1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
